// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer owning pc/ir, fetch/data handshakes, strobes and next-pc.
// Ports: clk, rst_n (async active-low); imem_req/imem_addr/imem_ready/imem_rdata fetch port;
//   pc, ir to decoder; imm, rs1_val, br_taken from datapath; alu_src_imm, dmem_req, dmem_we,
//   dmem_ready data port; rf_we, wb_sel writeback control; instret, halted, illegal status.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        br_taken,
  output logic        alu_src_imm,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] instret,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t      state;
  logic [31:0] target;
  logic [6:0]  opc;
  logic        is_load, is_store, is_opimm, is_op, is_branch, is_jal, is_jalr;
  logic        is_lui, is_auipc, is_misc, is_sys, known, wr_rd;
  logic [1:0]  sel;
  logic [31:0] next_tgt;
  assign opc       = ir[6:0];
  assign is_load   = opc == 7'b0000011;
  assign is_store  = opc == 7'b0100011;
  assign is_opimm  = opc == 7'b0010011;
  assign is_op     = opc == 7'b0110011;
  assign is_branch = opc == 7'b1100011;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111;
  assign is_lui    = opc == 7'b0110111;
  assign is_auipc  = opc == 7'b0010111;
  assign is_misc   = opc == 7'b0001111;
  assign is_sys    = opc == 7'b1110011;
  assign known     = is_load | is_store | is_opimm | is_op | is_branch | is_jal | is_jalr |
                     is_lui | is_auipc | is_misc | is_sys;
  assign wr_rd     = (is_load | is_opimm | is_op | is_jal | is_jalr | is_lui | is_auipc) &&
                     ir[11:7] != 5'd0;
  assign sel       = is_load ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
  assign next_tgt  = is_jalr ? ((rs1_val + imm) & ~32'd1) :
                     (is_jal | (is_branch & br_taken)) ? pc + imm : pc + 32'd4;
  assign imem_addr = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= 32'd0;
      target      <= 32'd0;
      instret     <= 32'd0;
      imem_req    <= 1'b1;
      alu_src_imm <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      rf_we       <= 1'b0;
      wb_sel      <= 2'b00;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          ir       <= imem_rdata;
          imem_req <= 1'b0;
          state    <= DECODE;
        end
        DECODE: begin
          if (!known || is_sys) begin
            halted  <= 1'b1;
            illegal <= !known;
            state   <= HALT;
          end else begin
            // operand-B select is held through MEM/WB so the shared ALU output stays valid
            alu_src_imm <= is_load | is_store | is_opimm | is_jalr;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (next_tgt[1]) begin
            halted      <= 1'b1;
            illegal     <= 1'b1;
            alu_src_imm <= 1'b0;
            state       <= HALT;
          end else if (is_load | is_store) begin
            target   <= next_tgt;
            dmem_req <= 1'b1;
            dmem_we  <= is_store;
            state    <= MEM;
          end else begin
            target <= next_tgt;
            rf_we  <= wr_rd;
            wb_sel <= sel;
            state  <= WB;
          end
        end
        MEM: if (dmem_ready) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          rf_we    <= wr_rd;
          wb_sel   <= sel;
          state    <= WB;
        end
        WB: begin
          pc          <= target;
          instret     <= instret + 32'd1;
          rf_we       <= 1'b0;
          wb_sel      <= 2'b00;
          alu_src_imm <= 1'b0;
          imem_req    <= 1'b1;
          state       <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        br_taken;
  logic        alu_src_imm;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [31:0] instret;
  logic        halted;
  logic        illegal;
  int n_checks = 0;
  int n_fail = 0;
  int cyc, rf_cnt, dreq_cnt;
  logic we_seen, ais_seen, addr_bad, ir_bad;
  logic [1:0] wsel;
  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .ir(ir), .imm(imm), .rs1_val(rs1_val), .br_taken(br_taken),
    .alu_src_imm(alu_src_imm), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // Runs one instruction from a FETCH-state negedge until the next FETCH or HALT.
  task automatic run(input logic [31:0] ins, input int fw, input logic [31:0] im,
                     input logic [31:0] r1, input logic bt, input int dw);
    logic [31:0] a0, i0;
    a0 = imem_addr;
    i0 = ir;
    imem_rdata = ins;
    imm = im;
    rs1_val = r1;
    br_taken = bt;
    cyc = 0; rf_cnt = 0; dreq_cnt = 0;
    we_seen = 0; ais_seen = 0; addr_bad = 0; ir_bad = 0; wsel = 2'b00;
    for (int i = 0; i < fw; i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      cyc++;
      if (imem_addr !== a0 || imem_req !== 1'b1) addr_bad = 1;
      if (ir !== i0) ir_bad = 1;
    end
    imem_ready = 1'b1;
    @(negedge clk);
    cyc++;
    imem_ready = 1'b0;
    while (imem_req !== 1'b1 && halted !== 1'b1 && cyc < 100) begin
      if (dmem_req) begin
        dreq_cnt++;
        we_seen |= dmem_we;
      end
      dmem_ready = dmem_req && (dreq_cnt == dw + 1);
      if (rf_we) begin
        rf_cnt++;
        wsel = wb_sel;
      end
      ais_seen |= alu_src_imm;
      @(negedge clk);
      cyc++;
    end
    dmem_ready = 1'b0;
    chk("bounded", 32'(cyc < 100), 32'd1);
  endtask
  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'd0; imm = 32'd0; rs1_val = 32'd0;
    br_taken = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_flags", {rf_we, dmem_req, dmem_we, halted, illegal}, 32'h0);
    rst_n = 1'b1;
    chk("fetch_req", {imem_req, imem_addr}, {1'b1, 32'h0});
    run(32'h00500093, 0, 32'd5, 32'd0, 1'b0, 0);
    chk("addi_lat", cyc, 4);
    chk("addi_rf", rf_cnt, 1);
    chk("addi_wbsel", wsel, 2'b00);
    chk("addi_srcimm", ais_seen, 1);
    chk("addi_pc", pc, 32'h4);
    chk("addi_instret", instret, 1);
    run(32'h00100113, 3, 32'd1, 32'd0, 1'b0, 0);
    chk("wait_addr", addr_bad, 0);
    chk("wait_ir", ir_bad, 0);
    chk("wait_lat", cyc, 7);
    chk("wait_ir_new", ir, 32'h00100113);
    chk("wait_pc", pc, 32'h8);
    run(32'h0000000F, 0, 32'd0, 32'd0, 1'b0, 0);
    chk("fence_rf", rf_cnt, 0);
    chk("fence_pc", pc, 32'hC);
    run(32'h002081B3, 0, 32'd0, 32'd0, 1'b0, 0);
    chk("add_rf", rf_cnt, 1);
    chk("add_srcimm", ais_seen, 0);
    chk("add_pc", pc, 32'h10);
    run(32'hFE208CE3, 0, 32'hFFFF_FFF8, 32'd0, 1'b1, 0);
    chk("beq_t_pc", pc, 32'h08);
    chk("beq_t_rf", rf_cnt, 0);
    run(32'h0100026F, 0, 32'd8, 32'd0, 1'b0, 0);
    chk("jal_pc", pc, 32'h10);
    chk("jal_wbsel", wsel, 2'b10);
    run(32'hFE208CE3, 0, 32'hFFFF_FFF8, 32'd0, 1'b0, 0);
    chk("beq_nt_pc", pc, 32'h14);
    chk("beq_nt_rf", rf_cnt, 0);
    chk("beq_instret", instret, 7);
    run(32'h00112023, 0, 32'd0, 32'd0, 1'b0, 2);
    chk("sw_dreq", dreq_cnt, 3);
    chk("sw_we", we_seen, 1);
    chk("sw_rf", rf_cnt, 0);
    chk("sw_lat", cyc, 7);
    chk("sw_instret", instret, 8);
    chk("sw_pc", pc, 32'h18);
    run(32'h0000A183, 0, 32'd0, 32'd0, 1'b0, 0);
    chk("lw_lat", cyc, 5);
    chk("lw_we", we_seen, 0);
    chk("lw_rf", rf_cnt, 1);
    chk("lw_wbsel", wsel, 2'b01);
    run(32'h123450B7, 0, 32'h12345000, 32'd0, 1'b0, 0);
    chk("lui_wbsel", wsel, 2'b11);
    run(32'h12345037, 0, 32'h12345000, 32'd0, 1'b0, 0);
    chk("lui_x0_rf", rf_cnt, 0);
    run(32'h00001097, 0, 32'h1000, 32'd0, 1'b0, 0);
    chk("auipc_rf", {rf_cnt[7:0], 6'd0, wsel}, {8'd1, 8'd0});
    chk("auipc_pc", pc, 32'h28);
    run(32'h000080E7, 0, 32'd3, 32'h101, 1'b0, 0);
    chk("jalr_pc", pc, 32'h104);
    chk("jalr_wbsel", wsel, 2'b10);
    run(32'h000080E7, 0, 32'd0, 32'h102, 1'b0, 0);
    chk("mis_halt", {halted, illegal}, 2'b11);
    chk("mis_pc", pc, 32'h104);
    chk("mis_rf", rf_cnt, 0);
    chk("mis_instret", instret, 13);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_frozen", {imem_req, dmem_req, rf_we, pc}, {3'b000, 32'h104});
    end
    chk("halt_ir", ir, 32'h000080E7);
    do_reset();
    chk("rst2", {halted, illegal, pc, instret}, {2'b00, 32'h0, 32'h0});
    run(32'h0000007F, 0, 32'd0, 32'd0, 1'b0, 0);
    chk("illegal_op", {halted, illegal}, 2'b11);
    chk("illegal_lat", cyc, 2);
    do_reset();
    run(32'h00000073, 0, 32'd0, 32'd0, 1'b0, 0);
    chk("ecall", {halted, illegal, instret}, {2'b10, 32'h0});
    do_reset();
    run(32'h00500093, 0, 32'd5, 32'd0, 1'b0, 0);
    chk("pre_pc", pc, 32'h4);
    imem_rdata = 32'h0000A183;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mem_reached", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_dreq", dmem_req, 0);
    chk("abort_pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_fetch", {imem_req, imem_addr}, {1'b1, 32'h0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", {rf_we, dmem_req}, 2'b00);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
